cpu_control: RTL and testbench
==============================

// Module: cpu_control
// PURPOSE
//  Instruction-sequencing FSM for the 16-bit processor datapath.
//  Covers fetch, execute, memory access, load writeback and interrupt entry.
//  Drives every datapath control strobe from Ir and Flags.
//  Owns the external memory handshake; sits beside the datapath in the processor top level.
// PARAMETERS
//  WAIT_MAX  15  cycles a FETCH/MEM access may wait for MemReady before FAULT (legal 1..255)
// PORTS
//  Clock     in   1   system clock, rising edge
//  Reset     in   1   asynchronous, active-high reset
//  Ir        in   16  instruction register contents from datapath
//  Flags     in   4   {Z,C,V,N} = Flags[3:0]
//  MemReady  in   1   memory access complete this cycle
//  Irq       in   1   level-sensitive interrupt request
//  MemRead   out  1   memory read request
//  MemWrite  out  1   memory write request
//  Ale       out  1   SysBus holds an address; external latch captures it
//  IntAck    out  1   one-cycle interrupt acknowledge
//  Fault     out  1   sticky memory-timeout indication
//  AluEn AluWe CFlag ImmSel IrWe LrEn LrSel LrWe MemEn Op1Sel Op2Sel PcEn PcWe RegWe WdSel
//            out  1   datapath strobes (one bit each)
//  PcSel Rs1Sel RwSel  out  2   datapath selects
// BEHAVIOUR
//  Outputs and state decode
//  - Outputs are combinational from state, Ir, Flags and MemReady; any output not listed for a state = 0.
//  - While Reset=1 every output = 0. Reset forces state=FETCH, wait counter=0, IE=1.
//  - Reset mid-access aborts the access; no partial register or PC write.
//  - States: FETCH, EXEC, MEM, WB, INT, FAULT. Class = Ir[15:14].
//  FETCH
//  - PcEn=1, Ale=1, MemRead=1 while waiting.
//  - On MemReady: IrWe=1, PcWe=1, PcSel=00 (PC+1); go to EXEC.
//  EXEC, class 00 (ALU reg-reg), single cycle
//  - Rs1Sel=00, RwSel=00, AluEn=1, AluWe=1, RegWe=1, WdSel=0.
//  - CFlag=Flags[2] when Ir[10]=1, else 0.
//  EXEC, class 01 (ALU immediate)
//  - As class 00, plus Op2Sel=1 and ImmSel=Ir[13].
//  EXEC, class 10 (load/store)
//  - AluEn=1, Op2Sel=1, ImmSel=0, Ale=1; go to MEM.
//  MEM
//  - Ir[13]=0 (load): MemRead=1; on MemReady go to WB.
//  - Ir[13]=1 (store): MemEn=1, MemWrite=1; on MemReady go to FETCH.
//  WB
//  - RegWe=1, WdSel=1 (DataIn), RwSel=00; go to FETCH.
//  EXEC, class 11 (flow control), selected by Ir[13:12], always ImmSel=1
//  - 00 BR:   PcSel=01, PcWe=1.
//  - 01 BRc:  PcSel=01, PcWe=|(Flags & Ir[11:8]).
//  - 10 BL:   LrWe=1, LrSel=0, PcSel=01, PcWe=1.
//  - 11 RET:  LrEn=1, PcSel=10, PcWe=1; IE<=1.
//  Interrupt entry
//  - Any transition headed to FETCH goes to INT instead when Irq=1 and IE=1.
//  - INT: LrSel=1, LrWe=1, PcSel=11 (vector), PcWe=1, IntAck=1; IE<=0; go to FETCH.
//  - An ISR entered from inside a BL callee overwrites LR; software saves LR first.
//  Wait counter and FAULT
//  - Counter clears on entry to FETCH/MEM and increments on each cycle with MemReady=0.
//  - Counter==WAIT_MAX with MemReady=0: go to FAULT.
//  - MemReady is ignored outside FETCH/MEM.
//  - FAULT: Fault=1 and all other outputs 0; exits only via Reset.
// TESTING
//  - Reset release, MemReady=1 with 0-cycle wait -> cycle1 FETCH strobes; cycle2 EXEC; fetch-to-next-fetch = 2 cycles for ALU ops.
//  - Load with MemReady delayed 3 cycles -> MemRead high 4 cycles, then WB with RegWe=1, WdSel=1 for exactly 1 cycle.
//  - BRc with Flags=4'b1000: Ir[11:8]=4'b1000 -> PcWe=1; Ir[11:8]=4'b0100 -> PcWe=0.
//  - Irq=1 during store MEM, IE=1 -> INT after MEM, IntAck 1 cycle, PcSel=11. Second Irq before RET -> ignored.
//  - MemReady held 0 in FETCH -> FAULT after WAIT_MAX+1=16 cycles, Fault stays 1 until Reset.
//  - Reset asserted mid-MEM -> all outputs 0 same cycle; restart in FETCH with IE=1.

Source files
------------

// File: rtl/cpu_control.sv
// Instruction-sequencing FSM for the 16-bit processor: fetch, execute, memory
// access, load writeback and interrupt entry, plus the memory-wait watchdog.
module cpu_control #(
  parameter int WAIT_MAX = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [15:0] Ir,
  input  logic [3:0] Flags,
  input  logic       MemReady,
  input  logic       Irq,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Ale,
  output logic       IntAck,
  output logic       Fault,
  output logic       AluEn,
  output logic       AluWe,
  output logic       CFlag,
  output logic       ImmSel,
  output logic       IrWe,
  output logic       LrEn,
  output logic       LrSel,
  output logic       LrWe,
  output logic       MemEn,
  output logic       Op1Sel,
  output logic       Op2Sel,
  output logic       PcEn,
  output logic       PcWe,
  output logic       RegWe,
  output logic       WdSel,
  output logic [1:0] PcSel,
  output logic [1:0] Rs1Sel,
  output logic [1:0] RwSel
);

  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, INT, FAULT} stateT;

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  stateT      state;
  stateT      nextState;
  stateT      fetchTarget;
  logic [7:0] waitCnt;
  logic       ie;
  logic       timeout;
  logic [1:0] opClass;
  logic [1:0] flowOp;
  logic       unusedIrBits;

  assign opClass      = Ir[15:14];
  assign flowOp       = Ir[13:12];
  assign timeout      = (waitCnt == WaitMax) && !MemReady;
  assign fetchTarget  = (Irq && ie) ? INT : FETCH;
  assign unusedIrBits = ^{Ir[9], Ir[7:0]};

  // State, wait counter and interrupt-enable registers. The counter only runs
  // while a FETCH/MEM access keeps waiting and restarts on every new access.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= FETCH;
      waitCnt <= 8'd0;
      ie      <= 1'b1;
    end else begin
      state <= nextState;
      if ((state == FETCH || state == MEM) && !MemReady && nextState == state)
        waitCnt <= waitCnt + 8'd1;
      else
        waitCnt <= 8'd0;
      if (state == INT)
        ie <= 1'b0;
      else if (state == EXEC && opClass == 2'b11 && flowOp == 2'b11)
        ie <= 1'b1;
    end
  end

  // Next-state logic; every path back to FETCH may be diverted into INT.
  always_comb begin
    nextState = state;
    case (state)
      FETCH: begin
        if (MemReady)     nextState = EXEC;
        else if (timeout) nextState = FAULT;
      end
      EXEC:    nextState = (opClass == 2'b10) ? MEM : fetchTarget;
      MEM: begin
        if (MemReady)     nextState = Ir[13] ? fetchTarget : WB;
        else if (timeout) nextState = FAULT;
      end
      WB:      nextState = fetchTarget;
      INT:     nextState = FETCH;
      FAULT:   nextState = FAULT;
      default: nextState = FETCH;
    endcase
  end

  // Output decode; holding Reset blanks every strobe even though state is FETCH.
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Ale      = 1'b0;
    IntAck   = 1'b0;
    Fault    = 1'b0;
    AluEn    = 1'b0;
    AluWe    = 1'b0;
    CFlag    = 1'b0;
    ImmSel   = 1'b0;
    IrWe     = 1'b0;
    LrEn     = 1'b0;
    LrSel    = 1'b0;
    LrWe     = 1'b0;
    MemEn    = 1'b0;
    Op1Sel   = 1'b0;
    Op2Sel   = 1'b0;
    PcEn     = 1'b0;
    PcWe     = 1'b0;
    RegWe    = 1'b0;
    WdSel    = 1'b0;
    PcSel    = 2'b00;
    Rs1Sel   = 2'b00;
    RwSel    = 2'b00;
    if (!Reset) begin
      case (state)
        FETCH: begin
          PcEn    = 1'b1;
          Ale     = 1'b1;
          MemRead = 1'b1;
          if (MemReady) begin
            IrWe = 1'b1;
            PcWe = 1'b1;
          end
        end
        EXEC: begin
          case (opClass)
            2'b00, 2'b01: begin
              AluEn = 1'b1;
              AluWe = 1'b1;
              RegWe = 1'b1;
              CFlag = Ir[10] & Flags[2];
              if (opClass == 2'b01) begin
                Op2Sel = 1'b1;
                ImmSel = Ir[13];
              end
            end
            2'b10: begin
              AluEn  = 1'b1;
              Op2Sel = 1'b1;
              Ale    = 1'b1;
            end
            default: begin
              ImmSel = 1'b1;
              case (flowOp)
                2'b00: begin
                  PcSel = 2'b01;
                  PcWe  = 1'b1;
                end
                2'b01: begin
                  PcSel = 2'b01;
                  PcWe  = |(Flags & Ir[11:8]);
                end
                2'b10: begin
                  LrWe  = 1'b1;
                  PcSel = 2'b01;
                  PcWe  = 1'b1;
                end
                default: begin
                  LrEn  = 1'b1;
                  PcSel = 2'b10;
                  PcWe  = 1'b1;
                end
              endcase
            end
          endcase
        end
        MEM: begin
          if (Ir[13]) begin
            MemEn    = 1'b1;
            MemWrite = 1'b1;
          end else begin
            MemRead = 1'b1;
          end
        end
        WB: begin
          RegWe = 1'b1;
          WdSel = 1'b1;
        end
        INT: begin
          LrSel  = 1'b1;
          LrWe   = 1'b1;
          PcSel  = 2'b11;
          PcWe   = 1'b1;
          IntAck = 1'b1;
        end
        FAULT:   Fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed-vector bench for cpu_control: each stimulus cycle queues its
// hand-computed strobe vector, and a negedge monitor pops and compares it.
module tb_cpu_control;

  logic        Clock;
  logic        Reset;
  logic [15:0] Ir;
  logic [3:0]  Flags;
  logic        MemReady;
  logic        Irq;
  logic        MemRead, MemWrite, Ale, IntAck, Fault;
  logic        AluEn, AluWe, CFlag, ImmSel, IrWe, LrEn, LrSel, LrWe, MemEn;
  logic        Op1Sel, Op2Sel, PcEn, PcWe, RegWe, WdSel;
  logic [1:0]  PcSel, Rs1Sel, RwSel;

  cpu_control #(.WAIT_MAX(15)) dut (
    .Clock(Clock), .Reset(Reset), .Ir(Ir), .Flags(Flags), .MemReady(MemReady), .Irq(Irq),
    .MemRead(MemRead), .MemWrite(MemWrite), .Ale(Ale), .IntAck(IntAck), .Fault(Fault),
    .AluEn(AluEn), .AluWe(AluWe), .CFlag(CFlag), .ImmSel(ImmSel), .IrWe(IrWe),
    .LrEn(LrEn), .LrSel(LrSel), .LrWe(LrWe), .MemEn(MemEn), .Op1Sel(Op1Sel),
    .Op2Sel(Op2Sel), .PcEn(PcEn), .PcWe(PcWe), .RegWe(RegWe), .WdSel(WdSel),
    .PcSel(PcSel), .Rs1Sel(Rs1Sel), .RwSel(RwSel)
  );

  localparam logic [25:0] MRD    = 26'd1 << 25;
  localparam logic [25:0] MWR    = 26'd1 << 24;
  localparam logic [25:0] ALE    = 26'd1 << 23;
  localparam logic [25:0] INTACK = 26'd1 << 22;
  localparam logic [25:0] FLT    = 26'd1 << 21;
  localparam logic [25:0] ALUEN  = 26'd1 << 20;
  localparam logic [25:0] ALUWE  = 26'd1 << 19;
  localparam logic [25:0] CFLAG  = 26'd1 << 18;
  localparam logic [25:0] IMMSEL = 26'd1 << 17;
  localparam logic [25:0] IRWE   = 26'd1 << 16;
  localparam logic [25:0] LREN   = 26'd1 << 15;
  localparam logic [25:0] LRSEL  = 26'd1 << 14;
  localparam logic [25:0] LRWE   = 26'd1 << 13;
  localparam logic [25:0] MEMEN  = 26'd1 << 12;
  localparam logic [25:0] OP2SEL = 26'd1 << 10;
  localparam logic [25:0] PCEN   = 26'd1 << 9;
  localparam logic [25:0] PCWE   = 26'd1 << 8;
  localparam logic [25:0] REGWE  = 26'd1 << 7;
  localparam logic [25:0] WDSEL  = 26'd1 << 6;
  localparam logic [25:0] PCS01  = 26'h10;
  localparam logic [25:0] PCS10  = 26'h20;
  localparam logic [25:0] PCS11  = 26'h30;

  localparam logic [25:0] NONE   = 26'd0;
  localparam logic [25:0] FWAIT  = MRD | ALE | PCEN;
  localparam logic [25:0] FRDY   = FWAIT | IRWE | PCWE;
  localparam logic [25:0] ALU    = ALUEN | ALUWE | REGWE;
  localparam logic [25:0] LDST   = ALUEN | OP2SEL | ALE;
  localparam logic [25:0] INTV   = LRSEL | LRWE | PCS11 | PCWE | INTACK;

  localparam logic [15:0] I_ALU  = 16'h0000;
  localparam logic [15:0] I_ALUC = 16'h0400;
  localparam logic [15:0] I_IMM  = 16'h6000;
  localparam logic [15:0] I_LD   = 16'h8000;
  localparam logic [15:0] I_ST   = 16'hA000;
  localparam logic [15:0] I_BR   = 16'hC000;
  localparam logic [15:0] I_BRC8 = 16'hD800;
  localparam logic [15:0] I_BRC4 = 16'hD400;
  localparam logic [15:0] I_BL   = 16'hE000;
  localparam logic [15:0] I_RET  = 16'hF000;

  logic [25:0] observed;
  assign observed = {MemRead, MemWrite, Ale, IntAck, Fault, AluEn, AluWe, CFlag, ImmSel,
                     IrWe, LrEn, LrSel, LrWe, MemEn, Op1Sel, Op2Sel, PcEn, PcWe, RegWe,
                     WdSel, PcSel, Rs1Sel, RwSel};

  string       nameQ[$];
  logic [25:0] expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;

  initial Clock = 1'b1;
  always #5 Clock = ~Clock;

  // Monitor: the DUT presents a strobe vector every cycle; compare mid-cycle.
  always @(negedge Clock) begin
    if (expQ.size() > 0) begin
      string       nm;
      logic [25:0] ex;
      nm = nameQ.pop_front();
      ex = expQ.pop_front();
      testsRun++;
      if (observed !== ex) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", nm, observed, ex);
      end
    end
  end

  task automatic applyStimulus(input string nm, input logic rst, input logic [15:0] ir,
                               input logic [3:0] fl, input logic rdy, input logic irq,
                               input logic [25:0] ex);
    Reset    = rst;
    Ir       = ir;
    Flags    = fl;
    MemReady = rdy;
    Irq      = irq;
    nameQ.push_back(nm);
    expQ.push_back(ex);
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput();
    int budget;
    budget = 10;
    while (expQ.size() > 0 && budget > 0) begin
      @(negedge Clock);
      budget--;
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
  endtask

  initial begin
    applyStimulus("reset",        1, I_ALU,  4'b0000, 1, 0, NONE);
    applyStimulus("fetch0",       0, I_ALUC, 4'b0100, 1, 0, FRDY);
    applyStimulus("execAluC",     0, I_ALUC, 4'b0100, 0, 0, ALU | CFLAG);
    applyStimulus("fetch1",       0, I_IMM,  4'b0100, 1, 0, FRDY);
    applyStimulus("execImm",      0, I_IMM,  4'b0100, 0, 0, ALU | OP2SEL | IMMSEL);

    applyStimulus("fetchLd",      0, I_LD,   4'b0000, 1, 0, FRDY);
    applyStimulus("execLd",       0, I_LD,   4'b0000, 0, 0, LDST);
    for (int i = 0; i < 3; i++)
      applyStimulus("memLdWait",  0, I_LD,   4'b0000, 0, 0, MRD);
    applyStimulus("memLdRdy",     0, I_LD,   4'b0000, 1, 0, MRD);
    applyStimulus("wb",           0, I_LD,   4'b0000, 0, 0, REGWE | WDSEL);
    applyStimulus("fetchAfterWb", 0, I_BRC8, 4'b1000, 0, 0, FWAIT);

    applyStimulus("fetchBrc8",    0, I_BRC8, 4'b1000, 1, 0, FRDY);
    applyStimulus("brcTaken",     0, I_BRC8, 4'b1000, 0, 0, IMMSEL | PCS01 | PCWE);
    applyStimulus("fetchBrc4",    0, I_BRC4, 4'b1000, 1, 0, FRDY);
    applyStimulus("brcNotTaken",  0, I_BRC4, 4'b1000, 0, 0, IMMSEL | PCS01);

    applyStimulus("fetchSt",      0, I_ST,   4'b0000, 1, 0, FRDY);
    applyStimulus("execSt",       0, I_ST,   4'b0000, 0, 0, LDST);
    applyStimulus("memStWait",    0, I_ST,   4'b0000, 0, 1, MEMEN | MWR);
    applyStimulus("memStRdy",     0, I_ST,   4'b0000, 1, 1, MEMEN | MWR);
    applyStimulus("intAfterSt",   0, I_ST,   4'b0000, 0, 1, INTV);
    applyStimulus("fetchIsr",     0, I_ALU,  4'b0000, 1, 1, FRDY);
    applyStimulus("execIsrAlu",   0, I_ALU,  4'b0000, 0, 1, ALU);
    applyStimulus("irqMasked",    0, I_RET,  4'b0000, 1, 1, FRDY);
    applyStimulus("ret",          0, I_RET,  4'b0000, 0, 1, IMMSEL | LREN | PCS10 | PCWE);
    applyStimulus("fetchAfterRet",0, I_BR,   4'b0000, 1, 1, FRDY);
    applyStimulus("br",           0, I_BR,   4'b0000, 0, 1, IMMSEL | PCS01 | PCWE);
    applyStimulus("intAfterBr",   0, I_BR,   4'b0000, 0, 0, INTV);
    applyStimulus("fetchBl",      0, I_BL,   4'b0000, 1, 0, FRDY);
    applyStimulus("bl",           0, I_BL,   4'b0000, 0, 0, IMMSEL | LRWE | PCS01 | PCWE);

    applyStimulus("fetchLd2",     0, I_LD,   4'b0000, 1, 0, FRDY);
    applyStimulus("execLd2",      0, I_LD,   4'b0000, 0, 0, LDST);
    applyStimulus("memLd2Wait",   0, I_LD,   4'b0000, 0, 0, MRD);
    applyStimulus("resetMidMem",  1, I_LD,   4'b0000, 0, 0, NONE);
    applyStimulus("fetchAfterRst",0, I_ALU,  4'b0000, 0, 0, FWAIT);
    applyStimulus("fetchIeCheck", 0, I_ALU,  4'b0000, 1, 1, FRDY);
    applyStimulus("execIeCheck",  0, I_ALU,  4'b0000, 0, 1, ALU);
    applyStimulus("intAfterRst",  0, I_ALU,  4'b0000, 0, 0, INTV);

    for (int i = 0; i < 16; i++)
      applyStimulus("fetchStall", 0, I_ALU,  4'b0000, 0, 0, FWAIT);
    for (int i = 0; i < 4; i++)
      applyStimulus("faultSticky",0, I_ALU,  4'b0000, 1, 1, FLT);
    applyStimulus("resetFault",   1, I_ALU,  4'b0000, 0, 0, NONE);
    applyStimulus("fetchRecover", 0, I_ALU,  4'b0000, 0, 0, FWAIT);

    checkOutput();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
